// File: rtl/pmux_pkg.sv
// Shared definitions for the pmux select path: select-code constants,
// grant classes and arbiter FSM states.
package pmux_pkg;
  localparam int SEL_W = 3;
  localparam logic [SEL_W-1:0] SEL_DEFAULT = 3'd7;

  typedef enum logic [1:0] {
    CLS_HI  = 2'd0,
    CLS_LO  = 2'd1,
    CLS_DEF = 2'd2
  } grant_cls_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  // Lane pointers live in 0..6, so 6 wraps straight back to 0.
  function automatic logic [SEL_W-1:0] ptr_next(input logic [SEL_W-1:0] lane);
    return (lane == 3'd6) ? 3'd0 : lane + 3'd1;
  endfunction
endpackage

// File: rtl/pmux_sel_arb_rr_pick7.sv
// Combinational round-robin finder over 7 request bits: first set bit at or
// above ptr, wrapping 6 -> 0.
module rr_pick7
  import pmux_pkg::*;
(
  input  logic [6:0]       req,
  input  logic [SEL_W-1:0] ptr,
  output logic             found,
  output logic [SEL_W-1:0] idx
);
  always_comb begin
    found = 1'b0;
    idx   = '0;
    // Walk farthest-first so the nearest hit to ptr is the last write.
    for (int i = 6; i >= 0; i--) begin
      int j;
      j = int'(ptr) + i;
      if (j >= 7) j = j - 7;
      if (req[j]) begin
        found = 1'b1;
        idx   = SEL_W'(j);
      end
    end
  end
endmodule

// File: rtl/pmux_sel_arb.sv
// Three-class grant arbiter feeding the pmux select codes; one registered
// grant at a time, held until acked, with a starvation bound for low class.
module pmux_sel_arb
  import pmux_pkg::*;
#(
  parameter int STARVE_LIMIT = 15
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [6:0]       hi_req_i,
  input  logic [6:0]       lo_req_i,
  input  logic             def_req_i,
  input  logic             ack_i,
  output logic             valid_o,
  output logic [SEL_W-1:0] sel_0_o,
  output logic [SEL_W-1:0] sel_1_o,
  output logic [SEL_W-1:0] sel_2_o,
  output logic [SEL_W-1:0] sel_3_o,
  output logic [1:0]       grant_cls_o
);
  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  state_e           state;
  grant_cls_e       cls_q;
  logic [SEL_W-1:0] hi_ptr, lo_ptr;
  logic [7:0]       starve_cnt;

  logic             hi_found, lo_found;
  logic [SEL_W-1:0] hi_idx, lo_idx;

  rr_pick7 u_pick_hi (.req(hi_req_i), .ptr(hi_ptr), .found(hi_found), .idx(hi_idx));
  rr_pick7 u_pick_lo (.req(lo_req_i), .ptr(lo_ptr), .found(lo_found), .idx(lo_idx));

  logic       grant_any;
  grant_cls_e nxt_cls;
  logic       decide;

  assign decide = (state == ST_IDLE) || ack_i;

  always_comb begin
    grant_any = 1'b1;
    nxt_cls   = CLS_DEF;
    if (lo_found && starve_cnt == LIMIT) nxt_cls = CLS_LO;
    else if (hi_found)                   nxt_cls = CLS_HI;
    else if (lo_found)                   nxt_cls = CLS_LO;
    else if (def_req_i)                  nxt_cls = CLS_DEF;
    else                                 grant_any = 1'b0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= ST_IDLE;
      sel_0_o    <= SEL_DEFAULT;
      sel_1_o    <= SEL_DEFAULT;
      cls_q      <= CLS_DEF;
      hi_ptr     <= '0;
      lo_ptr     <= '0;
      starve_cnt <= '0;
    end else if (decide) begin
      if (!grant_any) begin
        state   <= ST_IDLE;
        sel_0_o <= SEL_DEFAULT;
        sel_1_o <= SEL_DEFAULT;
        cls_q   <= CLS_DEF;
      end else begin
        state <= ST_GRANT;
        cls_q <= nxt_cls;
        unique case (nxt_cls)
          CLS_HI: begin
            sel_0_o <= hi_idx;
            sel_1_o <= SEL_DEFAULT;
            hi_ptr  <= ptr_next(hi_idx);
            // Only count hi wins that actually blocked a waiting lo request.
            if (!lo_found)          starve_cnt <= '0;
            else if (starve_cnt != LIMIT) starve_cnt <= starve_cnt + 8'd1;
          end
          CLS_LO: begin
            sel_0_o    <= SEL_DEFAULT;
            sel_1_o    <= lo_idx;
            lo_ptr     <= ptr_next(lo_idx);
            starve_cnt <= '0;
          end
          default: begin
            sel_0_o <= SEL_DEFAULT;
            sel_1_o <= SEL_DEFAULT;
          end
        endcase
      end
    end
  end

  assign valid_o     = (state == ST_GRANT);
  assign grant_cls_o = cls_q;
  assign sel_2_o     = SEL_DEFAULT;
  assign sel_3_o     = SEL_DEFAULT;
endmodule

// File: tb/tb_pmux_sel_arb.sv
// Randomized + directed bench for pmux_sel_arb against a behavioural model.
module tb_pmux_sel_arb;
  localparam int LIMIT = 3;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic [6:0] hi_req_i = '0, lo_req_i = '0;
  logic       def_req_i = 1'b0, ack_i = 1'b0;
  logic       valid_o;
  logic [2:0] sel_0_o, sel_1_o, sel_2_o, sel_3_o;
  logic [1:0] grant_cls_o;

  pmux_sel_arb #(.STARVE_LIMIT(LIMIT)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .hi_req_i(hi_req_i), .lo_req_i(lo_req_i),
    .def_req_i(def_req_i), .ack_i(ack_i), .valid_o(valid_o),
    .sel_0_o(sel_0_o), .sel_1_o(sel_1_o), .sel_2_o(sel_2_o), .sel_3_o(sel_3_o),
    .grant_cls_o(grant_cls_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0, failures = 0;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  // Model: grant as (valid, class, lane); sel codes derived from that.
  int m_valid, m_cls, m_lane, m_hptr, m_lptr, m_starve;

  function automatic int pick(input logic [6:0] req, input int ptr);
    for (int i = 0; i < 7; i++)
      if (req[(ptr + i) % 7]) return (ptr + i) % 7;
    return -1;
  endfunction

  task automatic model_reset();
    m_valid = 0; m_cls = 2; m_lane = 7; m_hptr = 0; m_lptr = 0; m_starve = 0;
  endtask

  task automatic model_edge();
    int l;
    if (m_valid == 1 && ack_i == 1'b0) return;
    if (lo_req_i != 0 && m_starve == LIMIT) begin
      l = pick(lo_req_i, m_lptr); m_valid = 1; m_cls = 1; m_lane = l;
      m_lptr = (l + 1) % 7; m_starve = 0;
    end else if (hi_req_i != 0) begin
      l = pick(hi_req_i, m_hptr); m_valid = 1; m_cls = 0; m_lane = l;
      m_hptr = (l + 1) % 7;
      m_starve = (lo_req_i != 0) ? ((m_starve + 1 > LIMIT) ? LIMIT : m_starve + 1) : 0;
    end else if (lo_req_i != 0) begin
      l = pick(lo_req_i, m_lptr); m_valid = 1; m_cls = 1; m_lane = l;
      m_lptr = (l + 1) % 7; m_starve = 0;
    end else if (def_req_i) begin
      m_valid = 1; m_cls = 2; m_lane = 7;
    end else begin
      m_valid = 0; m_cls = 2; m_lane = 7;
    end
  endtask

  task automatic check_outs(input string tag);
    chk({tag, ".valid"}, int'(valid_o), m_valid);
    chk({tag, ".sel0"}, int'(sel_0_o), (m_valid == 1 && m_cls == 0) ? m_lane : 7);
    chk({tag, ".sel1"}, int'(sel_1_o), (m_valid == 1 && m_cls == 1) ? m_lane : 7);
    chk({tag, ".cls"}, int'(grant_cls_o), m_valid == 1 ? m_cls : 2);
    chk({tag, ".sel23"}, int'({sel_2_o, sel_3_o}), 63);
  endtask

  // Inputs are applied #1 after an edge; model evaluates them at the next edge.
  task automatic step(input string tag);
    model_edge();
    @(posedge clk_i); #1;
    check_outs(tag);
  endtask

  task automatic do_reset();
    hi_req_i = '0; lo_req_i = '0; def_req_i = 1'b0; ack_i = 1'b0;
    #3 rst_i = 1'b1;
    #1;
    model_reset();
    check_outs("rst_async");
    @(posedge clk_i); #1;
    rst_i = 1'b0;
  endtask

  initial begin
    model_reset();
    @(posedge clk_i); #1;
    check_outs("rst_init");
    rst_i = 1'b0;

    // Hi round-robin over lanes 0 and 2 with continuous ack.
    hi_req_i = 7'b0000101; ack_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step("hi_rr");
      chk("hi_rr.seq", int'(sel_0_o), (i % 2 == 0) ? 0 : 2);
    end

    // Reset while a grant is presented, then restart from pointer 0.
    do_reset();
    hi_req_i = 7'b0000101; ack_i = 1'b1;
    step("post_rst");
    chk("post_rst.lane0", int'(sel_0_o), 0);

    // Lo only, def only, then nothing.
    hi_req_i = '0; lo_req_i = 7'b0010000;
    step("lo4");
    lo_req_i = '0; def_req_i = 1'b1;
    step("def");
    def_req_i = 1'b0;
    step("drop");
    step("idle");

    // Starvation bound: hi, hi, hi, lo repeating.
    do_reset();
    hi_req_i = 7'b0000010; lo_req_i = 7'b0100000; ack_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step("starve");
      chk("starve.cls", int'(grant_cls_o), (i % 4 == 3) ? 1 : 0);
    end

    // Hold: grant frozen without ack while requests change.
    do_reset();
    hi_req_i = 7'b0001000; ack_i = 1'b0;
    step("hold.g");
    hi_req_i = 7'b1000000;
    for (int i = 0; i < 5; i++) begin
      step("hold");
      chk("hold.sel0", int'(sel_0_o), 3);
    end
    ack_i = 1'b1;
    step("hold.next");
    chk("hold.next6", int'(sel_0_o), 6);

    // Wrap: pointer at 6 picks 6 then 0.
    do_reset();
    hi_req_i = 7'b0100000; ack_i = 1'b1;
    step("wrap.5");
    hi_req_i = 7'b1000001;
    step("wrap.6");
    chk("wrap.lane6", int'(sel_0_o), 6);
    step("wrap.0");
    chk("wrap.lane0", int'(sel_0_o), 0);

    // Ack while idle is harmless.
    hi_req_i = '0; step("drain"); step("idle_ack");

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      hi_req_i  = ($urandom_range(0, 3) == 0) ? 7'($urandom) : 7'd0;
      lo_req_i  = ($urandom_range(0, 2) == 0) ? 7'($urandom) : 7'd0;
      def_req_i = ($urandom_range(0, 3) == 0);
      ack_i     = ($urandom_range(0, 2) != 0);
      step("rand");
      if (i == 200) do_reset();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pmux_sel_arb.md
# pmux_sel_arb

Arbiter stage directly upstream of the `pmux` select-mux. Collects per-lane requests in three priority classes and issues one registered grant at a time as the `sel_0_i`/`sel_1_i` code pair the mux consumes:
- high class through `sel_0` (mux offsets +1..+7);
- low class through `sel_1` (offsets +8..+14);
- default lane 7 through both codes at 7.

Each grant is held with a valid/ack handshake. Round-robin fairness applies within each class, and a starvation limit bounds how long low-class requests can be blocked.

## Interface
Parameters:
- `STARVE_LIMIT`, default 15: consecutive high-class grants allowed while a low-class request is pending. Legal range 1..255.

Ports:
- `clk_i`  in  1  clock; the block uses one clock.
- `rst_i`  in  1  asynchronous, active-high reset.
- `hi_req_i`  in  7  high-class requests, lanes 0..6.
- `lo_req_i`  in  7  low-class requests, lanes 0..6.
- `def_req_i`  in  1  default-lane (lane 7) request.
- `ack_i`  in  1  downstream has consumed the current grant.
- `valid_o`  out  1  a grant is presented on the sel outputs.
- `sel_0_o`  out  3  primary select code; 7 = fall through.
- `sel_1_o`  out  3  secondary select code; 7 = default lane.
- `sel_2_o`, `sel_3_o`  out  3 each  tied to constant 7.
- `grant_cls_o`  out  2  class of the current grant: 0 = hi, 1 = lo, 2 = def.

## Operation
- Reset values:
  - `valid_o` = 0
  - `sel_0_o` = `sel_1_o` = 7
  - `grant_cls_o` = 2
  - `hi_ptr` = `lo_ptr` = 0
  - `starve_cnt` = 0
  - state = IDLE
- States:
  - IDLE: `valid_o` = 0.
  - GRANT: `valid_o` = 1; outputs frozen.
- Decision point: any clock edge in IDLE, or an edge in GRANT where `ack_i` = 1. At that edge, requests are evaluated:
  1. If `lo_req_i` != 0 and `starve_cnt` == `STARVE_LIMIT`: grant lo.
  2. Else if `hi_req_i` != 0: grant hi.
  3. Else if `lo_req_i` != 0: grant lo.
  4. Else if `def_req_i` = 1: grant def.
  5. Else: no grant; go to or stay in IDLE.
- Lane choice within a class: the first set bit searching from that class pointer upward, wrapping 6 → 0. Lane 7 is never part of the search.
- Encoding of the grant:
  - hi lane L: `sel_0` = L, `sel_1` = 7, cls = 0.
  - lo lane L: `sel_0` = 7, `sel_1` = L, cls = 1.
  - def: `sel_0` = 7, `sel_1` = 7, cls = 2.
- Pointer update at grant issue: the granting class pointer becomes L+1, with 6 wrapping to 0. The other pointer is unchanged; a def grant changes neither pointer.
- `starve_cnt` update at grant issue:
  - hi grant with `lo_req_i` != 0: increment, saturating at `STARVE_LIMIT`.
  - hi grant with `lo_req_i` == 0: clear.
  - lo grant: clear.
  - def grant: unchanged.
- In GRANT, changes on `req_i` are ignored. The grant is not withdrawn even if its request drops.
- Requests are level-sensitive. Clearing a request is the requester's job after observing its grant acked.

## Timing
- Grant latency: requests present at decision edge N produce `valid_o` and the new sel codes registered at edge N, visible in cycle N+1.
- Back-to-back: `ack_i` together with pending requests at edge N loads the next grant directly. `valid_o` stays high with no bubble.
- `ack_i` with no requests: `valid_o` falls in the next cycle.
- `ack_i` while in IDLE is ignored.
- Outputs are stable from the cycle `valid_o` rises through the cycle in which `ack_i` is sampled high.
- Asynchronous reset mid-grant: all outputs and state take their reset values immediately. No grant is resumed after release.
- The first decision is at the first edge after `rst_i` deasserts.

## Structure
- Shared package `pmux_pkg` holds:
  - `SEL_DEFAULT` = 3'd7 and `SEL_W` = 3;
  - the grant-class enum (`CLS_HI`, `CLS_LO`, `CLS_DEF`);
  - the state enum (`ST_IDLE`, `ST_GRANT`).
- Sub-module `rr_pick7`: combinational round-robin finder over 7 bits.
  - Inputs: request vector and 3-bit pointer.
  - Outputs: found flag and 3-bit index.
  - Instantiated twice, once for hi and once for lo.
- Top level holds the FSM, pointers, starvation counter and output registers.

## Test plan
- Reset → assert `rst_i` mid-simulation with `valid_o` = 1 → `valid_o` = 0, sel = 7/7, cls = 2 in the same cycle; after release, first grant restarts with pointers at 0.
- Hi round-robin → `hi_req_i` = 7'b0000101, `ack_i` held at 1 → `sel_0_o` sequence 0, 2, 0, 2 with `sel_1_o` = 7 and `valid_o` continuously 1.
- Lo and def → only `lo_req_i` bit 4 → `sel_0`/`sel_1` = 7/4, cls 1. Then only `def_req_i` → 7/7, cls 2. Then nothing → `valid_o` drops one cycle after the ack.
- Starvation → `STARVE_LIMIT` = 3, hi lane 1 and lo lane 5 held, ack every cycle → classes hi, hi, hi, lo, hi, hi, hi, lo.
- Hold → grant on hi lane 3 with `ack_i` = 0 for 5 cycles while `hi_req_i` changes to lane 6 → outputs stay 3/7. After ack, the next grant is lane 6.
- Wrap → `hi_ptr` at 6 with `hi_req_i` = 7'b1000001 → grants 6, then 0.
